// File: rtl/car_alarm_controller.sv
// -----------------------------------------------------------------------------
// car_alarm_controller
//
// Purpose
//   Clocked, multi-door car alarm. An arm/disarm state machine watches the door
//   switches and the ignition. A shared down-counter times the entry delay
//   before the siren sounds, and then the length of each siren episode. The
//   legacy "lights left on" warning is kept here as a registered output.
//
// Optional feature
//   CAR_ALARM_HAZARD_BLINK_EN : when defined, HazardBlink toggles every
//   BLINK_HALF cycles while in ALARM. When undefined, HazardBlink is tied low,
//   no blink logic is built, and the BLINK_HALF parameter does not exist.
//
// Ports
//   Clock            in   1            system clock, rising edge
//   Reset_n          in   1            asynchronous, active-low reset
//   CarLightsOnSign  in   1            headlights on
//   OpenDoorSign     in   NUM_DOORS    1 = door i open (level)
//   IgnitionSignalOn in   1            ignition on
//   ArmReq           in   1            arm request, 1-cycle pulse
//   DisarmReq        in   1            disarm request, 1-cycle pulse
//   CarAlarmSignal   out  1            siren drive (registered)
//   LightsReminder   out  1            lights on & door open & ignition off
//   ArmedStatus      out  1            1 in ARMED, ENTRY and ALARM
//   AlarmState       out  2            0=DISARMED 1=ARMED 2=ENTRY 3=ALARM
//   TriggeredDoors   out  NUM_DOORS    sticky OR of doors seen open while set
//   AlarmCount       out  ALARM_CNT_W  alarm episodes since disarm, saturating
//   HazardBlink      out  1            hazard-lamp blink during ALARM
// -----------------------------------------------------------------------------
module car_alarm_controller #(
  parameter int NUM_DOORS   = 4,
  parameter int TIMER_W     = 16,
  parameter int ENTRY_DELAY = 16,
  parameter int SIREN_TIME  = 64,
  parameter int ALARM_CNT_W = 4
`ifdef CAR_ALARM_HAZARD_BLINK_EN
  ,
  parameter int BLINK_HALF  = 8
`endif
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   CarLightsOnSign,
  input  logic [NUM_DOORS-1:0]   OpenDoorSign,
  input  logic                   IgnitionSignalOn,
  input  logic                   ArmReq,
  input  logic                   DisarmReq,
  output logic                   CarAlarmSignal,
  output logic                   LightsReminder,
  output logic                   ArmedStatus,
  output logic [1:0]             AlarmState,
  output logic [NUM_DOORS-1:0]   TriggeredDoors,
  output logic [ALARM_CNT_W-1:0] AlarmCount,
  output logic                   HazardBlink
);

  // The encoding is visible on AlarmState, so it is fixed explicitly.
  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_ENTRY    = 2'd2,
    S_ALARM    = 2'd3
  } state_t;

  // Timer reload values. The timer counts down to zero, so an N-cycle
  // interval loads N-1.
  localparam logic [TIMER_W-1:0] LP_ENTRY_LOAD = TIMER_W'(ENTRY_DELAY - 1);
  localparam logic [TIMER_W-1:0] LP_SIREN_LOAD = TIMER_W'(SIREN_TIME - 1);

  state_t                 r_state;
  logic [TIMER_W-1:0]     r_timer;

  state_t                 w_next_state;
  logic [TIMER_W-1:0]     w_next_timer;
  logic                   w_trig;
  logic                   w_timer_zero;
  logic                   w_count_inc;
  logic                   w_count_full;
  logic                   w_lights_warn;

  // Any open door or a running ignition counts as an intrusion.
  assign w_trig        = (|OpenDoorSign) | IgnitionSignalOn;
  assign w_timer_zero  = (r_timer == '0);
  assign w_count_full  = &AlarmCount;
  assign w_lights_warn = CarLightsOnSign & (|OpenDoorSign) & ~IgnitionSignalOn;

  // ---------------------------------------------------------------------------
  // Next-state and timer logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default value first. A path that
  // leaves a combinational output unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_timer = r_timer;
    w_count_inc  = 1'b0;

    if (DisarmReq) begin
      // A disarm overrides every other transition in the same cycle.
      w_next_state = S_DISARMED;
      w_next_timer = '0;
    end else begin
      unique case (r_state)
        S_DISARMED: begin
          // An arm request while a door is open or the ignition is on is
          // dropped. It is not held pending.
          if (ArmReq && !w_trig) begin
            w_next_state = S_ARMED;
          end
        end

        S_ARMED: begin
          if (w_trig) begin
            w_next_state = S_ENTRY;
            w_next_timer = LP_ENTRY_LOAD;
          end
        end

        S_ENTRY: begin
          if (w_timer_zero) begin
            w_next_state = S_ALARM;
            w_next_timer = LP_SIREN_LOAD;
            w_count_inc  = 1'b1;
          end else begin
            w_next_timer = r_timer - TIMER_W'(1);
          end
        end

        S_ALARM: begin
          // After a timeout the state returns to ARMED. If the trigger is
          // still present, the next cycle starts a new episode.
          if (w_timer_zero) begin
            w_next_state = S_ARMED;
          end else begin
            w_next_timer = r_timer - TIMER_W'(1);
          end
        end

        default: begin
          w_next_state = S_DISARMED;
          w_next_timer = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, timer and registered outputs
  // ---------------------------------------------------------------------------
  // Outputs are decoded from the next state. They therefore change on the
  // same edge as AlarmState, with no extra cycle of lag.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever the statement order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state        <= S_DISARMED;
      r_timer        <= '0;
      CarAlarmSignal <= 1'b0;
      ArmedStatus    <= 1'b0;
      LightsReminder <= 1'b0;
      TriggeredDoors <= '0;
      AlarmCount     <= '0;
    end else begin
      r_state        <= w_next_state;
      r_timer        <= w_next_timer;
      CarAlarmSignal <= (w_next_state == S_ALARM);
      ArmedStatus    <= (w_next_state != S_DISARMED);
      LightsReminder <= w_lights_warn;

      if (DisarmReq) begin
        TriggeredDoors <= '0;
      end else if (r_state != S_DISARMED) begin
        TriggeredDoors <= TriggeredDoors | OpenDoorSign;
      end

      if (DisarmReq) begin
        AlarmCount <= '0;
      end else if (w_count_inc && !w_count_full) begin
        AlarmCount <= AlarmCount + ALARM_CNT_W'(1);
      end
    end
  end

  assign AlarmState = r_state;

  // ---------------------------------------------------------------------------
  // Hazard blink
  // ---------------------------------------------------------------------------
`ifdef CAR_ALARM_HAZARD_BLINK_EN
  localparam int BLINK_CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_CNT_W-1:0] LP_BLINK_LAST = BLINK_CNT_W'(BLINK_HALF - 1);

  logic [BLINK_CNT_W-1:0] r_blink_cnt;
  logic                   r_blink;

  // The lamp turns on with the siren. It then flips after each BLINK_HALF
  // cycles spent in ALARM, and clears when ALARM is left.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_next_state != S_ALARM) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_state != S_ALARM) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == LP_BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_CNT_W'(1);
    end
  end

  assign HazardBlink = r_blink;
`else
  assign HazardBlink = 1'b0;
`endif

endmodule

// File: tb/tb_car_alarm_controller.sv
module tb_car_alarm_controller;

  localparam int NUM_DOORS   = 4;
  localparam int ENTRY_DELAY = 16;
  localparam int SIREN_TIME  = 64;
  localparam int ALARM_CNT_W = 2;
  localparam int BLINK_HALF  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lights;
  logic [3:0] doors;
  logic       ign;
  logic       arm;
  logic       disarm;

  logic       siren;
  logic       lr;
  logic       armed;
  logic [1:0] state;
  logic [3:0] tdoors;
  logic [1:0] cnt;
  logic       hz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  car_alarm_controller #(
    .NUM_DOORS  (NUM_DOORS),
    .TIMER_W    (16),
    .ENTRY_DELAY(ENTRY_DELAY),
    .SIREN_TIME (SIREN_TIME),
    .ALARM_CNT_W(ALARM_CNT_W)
  ) dut (
    .Clock           (clk),
    .Reset_n         (rst_n),
    .CarLightsOnSign (lights),
    .OpenDoorSign    (doors),
    .IgnitionSignalOn(ign),
    .ArmReq          (arm),
    .DisarmReq       (disarm),
    .CarAlarmSignal  (siren),
    .LightsReminder  (lr),
    .ArmedStatus     (armed),
    .AlarmState      (state),
    .TriggeredDoors  (tdoors),
    .AlarmCount      (cnt),
    .HazardBlink     (hz)
  );

  typedef struct {
    string      name;
    logic [1:0] state;
    logic       siren;
    logic       lr;
    logic       armed;
    logic [3:0] tdoors;
    logic [1:0] cnt;
  } exp_t;

  typedef struct {
    logic       lights;
    logic [3:0] doors;
    logic       ign;
    logic       arm;
    logic       disarm;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic l, input logic [3:0] d,
                              input logic i, input logic a, input logic dis,
                              input logic [1:0] st, input logic s, input logic r,
                              input logic ar, input logic [3:0] td, input logic [1:0] c);
    vec_t v;
    v.lights = l; v.doors = d; v.ign = i; v.arm = a; v.disarm = dis;
    v.e.name = n; v.e.state = st; v.e.siren = s; v.e.lr = r;
    v.e.armed = ar; v.e.tdoors = td; v.e.cnt = c;
    return v;
  endfunction

  task automatic drive(input logic l, input logic [3:0] d, input logic i,
                       input logic a, input logic dis);
    lights = l; doors = d; ign = i; arm = a; disarm = dis;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_compare();
    exp_t e;
    check("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({e.name, "_state"},  32'(state),  32'(e.state));
      check({e.name, "_siren"},  32'(siren),  32'(e.siren));
      check({e.name, "_lr"},     32'(lr),     32'(e.lr));
      check({e.name, "_armed"},  32'(armed),  32'(e.armed));
      check({e.name, "_tdoors"}, 32'(tdoors), 32'(e.tdoors));
      check({e.name, "_cnt"},    32'(cnt),    32'(e.cnt));
    end
  endtask

  initial begin
    int hi_cycles;
    int blink_bad;
    int k;
    int siren_seen;
    int seq_bad;
    logic [1:0] prev_state;
    logic [1:0] prev_cnt;
    logic exp_hz;

    //            name          lt  doors   ig ar ds  st    sr lr am  td      cnt
    vecs[0]  = mk("idle",       0, 4'b0000, 0, 0, 0, 2'd0, 0, 0, 0, 4'b0000, 2'd0);
    vecs[1]  = mk("lr_on",      1, 4'b0001, 0, 0, 0, 2'd0, 0, 1, 0, 4'b0000, 2'd0);
    vecs[2]  = mk("lr_ign",     1, 4'b0001, 1, 0, 0, 2'd0, 0, 0, 0, 4'b0000, 2'd0);
    vecs[3]  = mk("arm_door2",  0, 4'b0100, 0, 1, 0, 2'd0, 0, 0, 0, 4'b0000, 2'd0);
    vecs[4]  = mk("arm_ign",    0, 4'b0000, 1, 1, 0, 2'd0, 0, 0, 0, 4'b0000, 2'd0);
    vecs[5]  = mk("arm_ok",     0, 4'b0000, 0, 1, 0, 2'd1, 0, 0, 1, 4'b0000, 2'd0);
    vecs[6]  = mk("arm_again",  0, 4'b0000, 0, 1, 0, 2'd1, 0, 0, 1, 4'b0000, 2'd0);
    vecs[7]  = mk("disarm_trg", 0, 4'b0010, 0, 0, 1, 2'd0, 0, 0, 0, 4'b0000, 2'd0);
    vecs[8]  = mk("rearm",      0, 4'b0000, 0, 1, 0, 2'd1, 0, 0, 1, 4'b0000, 2'd0);
    vecs[9]  = mk("armed_idle", 0, 4'b0000, 0, 0, 0, 2'd1, 0, 0, 1, 4'b0000, 2'd0);
    vecs[10] = mk("disarm",     0, 4'b0000, 0, 0, 1, 2'd0, 0, 0, 0, 4'b0000, 2'd0);
    vecs[11] = mk("rearm2",     0, 4'b0000, 0, 1, 0, 2'd1, 0, 0, 1, 4'b0000, 2'd0);

    // ---- reset ----
    rst_n = 1'b0;
    drive(0, 4'b0000, 0, 0, 0);
    #12;
    check("rst_siren",  32'(siren),  32'd0);
    check("rst_state",  32'(state),  32'd0);
    check("rst_armed",  32'(armed),  32'd0);
    check("rst_lr",     32'(lr),     32'd0);
    check("rst_tdoors", 32'(tdoors), 32'd0);
    check("rst_cnt",    32'(cnt),    32'd0);
    check("rst_hz",     32'(hz),     32'd0);
    rst_n = 1'b1;

    // ---- single-cycle vectors through the scoreboard ----
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].lights, vecs[i].doors, vecs[i].ign, vecs[i].arm, vecs[i].disarm);
      sb_q.push_back(vecs[i].e);
      tick();
      sb_compare();
    end
    drive(0, 4'b0000, 0, 0, 0);

    // ---- trigger: door1 for one cycle, siren 17 cycles later ----
    drive(0, 4'b0010, 0, 0, 0);
    tick();
    check("trig_state",  32'(state),  32'd2);
    check("trig_tdoors", 32'(tdoors), 32'b0010);
    check("trig_armed",  32'(armed),  32'd1);
    doors = 4'b0000;
    siren_seen = 0;
    for (int i = 0; i < ENTRY_DELAY - 1; i++) begin
      tick();
      if (siren !== 1'b0) siren_seen++;
    end
    check("entry_siren_early", 32'(siren_seen), 32'd0);
    check("entry_state_end",   32'(state),      32'd2);
    tick();
    check("alarm_siren", 32'(siren), 32'd1);
    check("alarm_state", 32'(state), 32'd3);
    check("alarm_cnt",   32'(cnt),   32'd1);

    // Siren length and blink pattern across the episode.
    hi_cycles = 1;
    blink_bad = 0;
    k = 0;
    for (int b = 0; b < 200 && state == 2'd3; b++) begin
`ifdef CAR_ALARM_HAZARD_BLINK_EN
      exp_hz = (((k / BLINK_HALF) % 2) == 0);
`else
      exp_hz = 1'b0;
`endif
      if (hz !== exp_hz) blink_bad++;
      k++;
      tick();
      if (siren === 1'b1) hi_cycles++;
    end
    check("siren_cycles",   32'(hi_cycles), 32'(SIREN_TIME));
    check("alarm_len",      32'(k),         32'(SIREN_TIME));
    check("blink_pattern",  32'(blink_bad), 32'd0);
    check("post_state",     32'(state),     32'd1);
    check("post_siren",     32'(siren),     32'd0);
    check("post_cnt",       32'(cnt),       32'd1);
    check("post_tdoors",    32'(tdoors),    32'b0010);
    check("post_hz",        32'(hz),        32'd0);

    // ---- disarm mid-ENTRY at timer==5 ----
    drive(0, 4'b1000, 0, 0, 0);
    tick();
    check("b_trig_state", 32'(state), 32'd2);
    doors = 4'b0000;
    siren_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (siren !== 1'b0) siren_seen++;
    end
    check("b_entry_state", 32'(state), 32'd2);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    if (siren !== 1'b0) siren_seen++;
    check("b_siren_never", 32'(siren_seen), 32'd0);
    check("b_state",       32'(state),      32'd0);
    check("b_armed",       32'(armed),      32'd0);
    check("b_cnt",         32'(cnt),        32'd0);
    check("b_tdoors",      32'(tdoors),     32'd0);
    tick();
    check("b_stay_state",  32'(state),      32'd0);

    // ---- saturation: door held open across many episodes ----
    drive(0, 4'b0000, 0, 1, 0);
    tick();
    arm = 1'b0;
    check("c_armed_state", 32'(state), 32'd1);
    doors = 4'b0001;
    seq_bad = 0;
    prev_state = state;
    prev_cnt = cnt;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (prev_state == 2'd3 && !(state == 2'd3 || state == 2'd1)) seq_bad++;
      if (prev_state == 2'd1 && state != 2'd2) seq_bad++;
      if (cnt < prev_cnt) seq_bad++;
      prev_state = state;
      prev_cnt = cnt;
    end
    check("c_sequence", 32'(seq_bad), 32'd0);
    check("c_cnt_sat",  32'(cnt),     32'd3);
    check("c_tdoors",   32'(tdoors),  32'b0001);

    // ---- asynchronous reset mid-ALARM ----
    k = 0;
    while (state != 2'd3 && k < 200) begin
      tick();
      k++;
    end
    check("d_reach_alarm", 32'(state), 32'd3);
    check("d_siren_on",    32'(siren), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("d_rst_siren",  32'(siren),  32'd0);
    check("d_rst_state",  32'(state),  32'd0);
    check("d_rst_armed",  32'(armed),  32'd0);
    check("d_rst_cnt",    32'(cnt),    32'd0);
    check("d_rst_tdoors", 32'(tdoors), 32'd0);
    check("d_rst_hz",     32'(hz),     32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("d_release_state", 32'(state), 32'd0);
    check("d_release_siren", 32'(siren), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
